// File: rtl/complete_multiplier_pkg.sv
// Shared sizing and state encoding for the carry-less
// polynomial multiplier datapath.
package complete_multiplier_pkg;

  localparam int N  = 17669;
  localparam int D  = 64;
  localparam int K  = (N + D - 1) / D;
  localparam int W2 = 2 * N;
  localparam int KD = K * D;
  localparam int PW = N + D - 1;
  localparam int CW = $clog2(K);

  typedef enum logic [1:0] {
    S_LOAD,
    S_COMPUTE,
    S_DONE
  } state_t;

endpackage

// File: rtl/complete_multiplier_gf2_digit_mul.sv
// Combinational N x D carry-less multiply: XOR of copies of
// the operand shifted by each set digit bit.
module gf2_digit_mul #(
  parameter int NW = 17669,
  parameter int DW = 64
) (
  input  logic [NW-1:0]    i_u,
  input  logic [DW-1:0]    i_d,
  output logic [NW+DW-2:0] o_p
);

  logic [NW+DW-2:0] w_u_ext;

  assign w_u_ext = {{(DW-1){1'b0}}, i_u};

  always_comb begin
    o_p = '0;
    for (int b = 0; b < DW; b++) begin
      if (i_d[b]) begin
        o_p = o_p ^ (w_u_ext << b);
      end
    end
  end

endmodule

// File: rtl/complete_multiplier.sv
// Digit-serial GF(2)[x] multiplier, Horner order from the
// most significant digit of V; result is the product << 1.
module complete_multiplier
  import complete_multiplier_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  U,
  input  logic [N-1:0]  V,
  output logic [W2-1:0] W,
  output logic          done
);

  state_t          r_state;
  logic [N-1:0]    r_u;
  logic [KD-1:0]   r_v;
  logic [CW-1:0]   r_cnt;
  logic [W2-1:0]   r_acc;
  logic            r_done;

  logic [D-1:0]    w_digit;
  logic [PW-1:0]   w_part;
  logic [W2-1:0]   w_next;

  // V is zero-padded above N so the top digit is always valid
  assign w_digit = r_v[KD-1 -: D];

  gf2_digit_mul #(
    .NW (N),
    .DW (D)
  ) u_dmul (
    .i_u (r_u),
    .i_d (w_digit),
    .o_p (w_part)
  );

  // The extra low zero bit realises the final << 1 directly
  assign w_next = (r_acc << D)
                ^ {{(W2-PW-1){1'b0}}, w_part, 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_LOAD;
      r_u     <= '0;
      r_v     <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_LOAD: begin
          r_u     <= U;
          r_v     <= {{(KD-N){1'b0}}, V};
          r_cnt   <= '0;
          r_acc   <= '0;
          r_state <= S_COMPUTE;
        end
        S_COMPUTE: begin
          r_acc <= w_next;
          r_v   <= r_v << D;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(K - 1)) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_LOAD;
        end
      endcase
    end
  end

  assign W    = r_acc;
  assign done = r_done;

endmodule

// File: tb/tb_complete_multiplier.sv
// Directed and model-checked vectors for complete_multiplier.
module tb_complete_multiplier;
  import complete_multiplier_pkg::*;

  localparam int LAT  = K + 1;
  localparam int TMAX = LAT + 100;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  U;
  logic [N-1:0]  V;
  logic [W2-1:0] W;
  logic          done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  complete_multiplier dut (
    .clk   (clk),
    .reset (reset),
    .U     (U),
    .V     (V),
    .W     (W),
    .done  (done)
  );

  task automatic chk(input string tag,
                     input logic [W2-1:0] got,
                     input logic [W2-1:0] exp);
    int fd;
    checks++;
    if (got !== exp) begin
      errors++;
      fd = -1;
      for (int i = 0; i < W2; i++) begin
        if (got[i] !== exp[i]) begin
          fd = i;
          break;
        end
      end
      $display("FAIL %s: got[63:0]=%h required[63:0]=%h first diff bit %0d",
               tag, got[63:0], exp[63:0], fd);
    end
  endtask

  function automatic logic [W2-1:0] clmul_ref(
    input logic [N-1:0] u,
    input logic [N-1:0] v
  );
    logic [W2-1:0] acc;
    logic [W2-1:0] su;
    acc = '0;
    su  = {{(N-1){1'b0}}, u, 1'b0};
    for (int j = 0; j < N; j++) begin
      if (v[j]) acc = acc ^ su;
      su = su << 1;
    end
    return acc;
  endfunction

  function automatic logic [N-1:0] rand_vec();
    logic [N-1:0] r;
    logic [31:0]  w;
    w = '0;
    for (int i = 0; i < N; i++) begin
      if (i % 32 == 0) w = $urandom;
      r[i] = w[i % 32];
    end
    return r;
  endfunction

  // One reset edge, release, then count edges until done;
  // inputs are scrambled after LOAD to prove they are ignored.
  task automatic run(input string tag,
                     input logic [N-1:0] u,
                     input logic [N-1:0] v,
                     input logic [W2-1:0] exp);
    int n;
    @(negedge clk);
    U = u;
    V = v;
    reset = 1'b1;
    @(negedge clk);
    chk({tag, "_rst_done"}, W2'(done), '0);
    chk({tag, "_rst_W"}, W, '0);
    reset = 1'b0;
    n = 0;
    while (n < TMAX) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        U = rand_vec();
        V = rand_vec();
      end
      if (done) break;
    end
    chk({tag, "_lat"}, W2'(n), W2'(LAT));
    chk({tag, "_W"}, W, exp);
  endtask

  initial begin
    logic [N-1:0]  u;
    logic [N-1:0]  v;
    logic [W2-1:0] e;

    reset = 1'b1;
    U = '0;
    V = '0;
    repeat (2) @(negedge clk);
    chk("por_done", W2'(done), '0);
    chk("por_W", W, '0);

    run("one", N'(1), N'(1), W2'(2));

    run("zero_u", '0, rand_vec() | N'(1), '0);

    u = '0;
    u[N-1] = 1'b1;
    e = '0;
    e[W2-1] = 1'b1;
    run("top", u, u, e);

    u = '1;
    e = {{(N-1){1'b0}}, {N{1'b1}}, 1'b0};
    run("ones_x1", u, N'(1), e);

    u = N'(128'd48923784923877589134);
    v = N'(128'd23984576993284592348);
    run("dec", u, v, clmul_ref(u, v));

    for (int i = 0; i < 20; i++) begin
      u = rand_vec();
      v = rand_vec();
      run($sformatf("rnd%0d", i), u, v, clmul_ref(u, v));
    end

    // Abort a computation part-way, then restart with 3 x 5
    @(negedge clk);
    U = rand_vec();
    V = rand_vec();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("abort_mid_done", W2'(done), '0);
    run("abort", N'(3), N'(5), W2'(30));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
